// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words for the instruction RAM
// and holds the core in reset until the image is written. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   word_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            len_lo_q  <= '0;
            n_q       <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            buf_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            n_q       <= n_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_d     = word_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        n_full     = {in_data_i, len_lo_q};
        word_inc   = word_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN0;
                    n_d     = '0;
                    word_d  = '0;
                    lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_LEN0: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
                    len_lo_d = in_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
                    if (n_full > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        n_d     = n_full[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ in_data_i;
`endif
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: buf_d[7:0]   = in_data_i;
                        2'd1: buf_d[15:8]  = in_data_i;
                        2'd2: buf_d[23:16] = in_data_i;
                        default: begin
                            // Write is registered so wr_* never sees in_data combinationally
                            wr_en_d   = 1'b1;
                            wr_addr_d = word_q[ADDR_W-1:0];
                            wr_data_d = {in_data_i, buf_q};
                            word_d    = word_inc;
                            if (word_inc == n_q) begin
                                state_d = S_FLUSH;
                            end
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                busy_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i) begin
                    state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign core_reset_o = (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);

endmodule
